// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack responder among N_REQ requesters.
// Optional WAIT_ACK abort timer is enabled with the ARB_TIMEOUT_EN macro.
module req_ack_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic                     m_req,
    input  logic                     m_ack,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned IdW = $clog2(N_REQ);
    localparam logic [IdW:0] NReqW = (IdW+1)'(N_REQ);
    localparam logic [IdW-1:0] LastId = IdW'(N_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StWaitRel
    } state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] gnt_q, gnt_d;
    logic [IdW-1:0] pick;
    logic [IdW:0]   idx_sum;
    logic           found;
    logic [IdW-1:0] gnt_next;

    // First set request at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        pick    = ptr_q;
        found   = 1'b0;
        idx_sum = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_sum = {1'b0, ptr_q} + (IdW+1)'(k);
            if (idx_sum >= NReqW) begin
                idx_sum = idx_sum - NReqW;
            end
            if (!found && req[idx_sum[IdW-1:0]]) begin
                found = 1'b1;
                pick  = idx_sum[IdW-1:0];
            end
        end
    end

    assign gnt_next = (gnt_q == LastId) ? '0 : gnt_q + IdW'(1);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       abort;
    logic       terr_q;

    assign abort = (state_q == StWaitAck) && !m_ack && (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StWaitAck) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= abort;
        end
    end

    assign timeout_err = terr_q;
`else
    logic abort;
    logic unused_timeout;

    assign abort          = 1'b0;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = pick;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                // A late m_ack beats the timer on the same cycle.
                if (m_ack) begin
                    state_d = StWaitRel;
                end else if (abort) begin
                    state_d = StIdle;
                    ptr_d   = gnt_next;
                end
            end
            StWaitRel: begin
                if (!m_ack && !req[gnt_q]) begin
                    state_d = StIdle;
                    ptr_d   = gnt_next;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == StWaitRel) begin
            ack[gnt_q] = 1'b1;
        end
    end

    assign m_req  = (state_q == StWaitAck);
    assign busy   = (state_q != StIdle);
    assign gnt_id = gnt_q;

endmodule
